palette_arbiter: RTL and testbench

// - Shares one combinational 32-entry RGB444 sprite palette ROM among NUM_REQ sprite pixel requesters (pacman, ghosts).
// - Picks one requester per cycle by round-robin and drives its 5-bit index to the palette.
// - Registers the returned colour with the winner's ID.
// - Sits between the sprite fetch units and the palette ROM; feeds the pixel compositor.

---
 rtl/palette_arb_pkg.sv | 23 ++
 rtl/palette_arbiter_rr_pick.sv | 29 ++
 rtl/palette_arbiter.sv | 93 +++++++++
 tb/tb_palette_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_arb_pkg.sv
// Shared types and constants for the sprite palette arbiter.
// The palette holds 32 RGB444 colours addressed by a 5-bit index.
package palette_arb_pkg;

  localparam int PAL_IDX_W   = 5;
  localparam int PAL_DEPTH   = 32;
  localparam int DEF_NUM_REQ = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Slot visited at step 'off' of a round-robin search that starts at 'base'.
  // Callers keep base below n, so one conditional subtract replaces a modulo.
  function automatic int rr_slot(int base, int off, int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/palette_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first asserted request at or after ptr, wrapping around.
module rr_pick
  import palette_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] winner,
  output logic         any
);

  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[rr_slot(int'(ptr), k, N)]) begin
        any                           = 1'b1;
        winner                        = W'(rr_slot(int'(ptr), k, N));
        gnt[rr_slot(int'(ptr), k, N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin sharing of one combinational palette ROM among sprite requesters.
// The returned colour is registered together with the winning requester's ID.
module palette_arbiter
  import palette_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = PAL_IDX_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] idx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [3:0]               pal_red,
  input  logic [3:0]               pal_green,
  input  logic [3:0]               pal_blue,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [11:0]              rsp_rgb,
  input  logic                     rsp_ready
);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  rgb444_t            rsp_rgb_q, rsp_rgb_d;

  logic               stall;
  logic               grant_ok;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_winner;
  logic               pick_any;

  assign stall = rsp_valid_q & ~rsp_ready;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .gnt    (pick_gnt),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Grants are suppressed while held in reset so no requester sees a phantom transfer.
  always_comb begin
    grant_ok  = pick_any & ~stall & ~Reset;
    gnt       = '0;
    pal_index = '0;
    if (grant_ok) begin
      gnt       = pick_gnt;
      pal_index = idx[int'(pick_winner)*IDX_W +: IDX_W];
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_rgb_d   = rsp_rgb_q;
    if (!stall) begin
      rsp_valid_d = grant_ok;
      if (grant_ok) begin
        rsp_id_d  = pick_winner;
        rsp_rgb_d = '{r: pal_red, g: pal_green, b: pal_blue};
        rr_ptr_d  = (pick_winner == ID_W'(NUM_REQ - 1)) ? '0 : pick_winner + ID_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rgb_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rgb_q   <= rsp_rgb_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rgb   = rsp_rgb_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Bench for palette_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level round-robin model and a response scoreboard.
module tb_palette_arbiter;

  localparam int N  = 4;
  localparam int IW = 5;
  localparam int DW = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [N-1:0]  req;
  logic [N*IW-1:0] idx;
  logic [N-1:0]  gnt;
  logic [IW-1:0] pal_index;
  logic [3:0]    pal_red, pal_green, pal_blue;
  logic          rsp_valid;
  logic [DW-1:0] rsp_id;
  logic [11:0]   rsp_rgb;
  logic          rsp_ready;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [11:0] m_rgb;
  int          exp_w;
  int          sb_id[$];
  logic [11:0] sb_rgb[$];

  // Random requester state
  bit          pending [N];
  logic [IW-1:0] pidx  [N];
  logic [N-1:0] gnt_seen;

  always #5 Clk = ~Clk;

  // Palette ROM contents: entries 0 and 1 are black, the rest a scrambled pattern.
  function automatic logic [11:0] pal_of(int i);
    return (i < 2) ? 12'h000 : 12'((i * 683) ^ 32'h5C3);
  endfunction

  always_comb {pal_red, pal_green, pal_blue} = pal_of(int'(pal_index));

  palette_arbiter #(
    .NUM_REQ (N),
    .IDX_W   (IW),
    .ID_W    (DW)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .idx       (idx),
    .gnt       (gnt),
    .pal_index (pal_index),
    .pal_red   (pal_red),
    .pal_green (pal_green),
    .pal_blue  (pal_blue),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rgb   (rsp_rgb),
    .rsp_ready (rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_first(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_id    = 0;
    m_rgb   = 12'h000;
    sb_id.delete();
    sb_rgb.delete();
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*IW-1:0] ix, input logic rdy);
    req       = r;
    idx       = ix;
    rsp_ready = rdy;
  endtask

  // Compare against the model for the current cycle, then advance the model.
  task automatic checkOutput(input string tag);
    bit stall;
    logic [11:0] want;
    stall = m_valid && !rsp_ready;
    exp_w = (!stall && !Reset) ? rr_first(req, m_ptr) : -1;
    gnt_seen = gnt;
    chk({tag, "_gnt"}, gnt, (exp_w < 0) ? 32'd0 : (32'd1 << exp_w));
    chk({tag, "_pidx"}, pal_index, (exp_w < 0) ? 32'd0 : 32'(idx[exp_w*IW +: IW]));
    chk({tag, "_valid"}, rsp_valid, m_valid);
    chk({tag, "_id"}, rsp_id, m_id);
    chk({tag, "_rgb"}, rsp_rgb, m_rgb);
    if (m_valid && rsp_ready && !Reset) begin
      if (sb_id.size() == 0) begin
        chk({tag, "_sb_extra"}, 32'd1, 32'd0);
      end else begin
        chk({tag, "_sb_id"}, rsp_id, sb_id.pop_front());
        chk({tag, "_sb_rgb"}, rsp_rgb, sb_rgb.pop_front());
      end
    end
    if (!stall && !Reset) begin
      if (exp_w >= 0) begin
        want    = pal_of(int'(idx[exp_w*IW +: IW]));
        m_valid = 1;
        m_id    = exp_w;
        m_rgb   = want;
        m_ptr   = (exp_w + 1) % N;
        sb_id.push_back(exp_w);
        sb_rgb.push_back(want);
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge Clk);
    checkOutput(tag);
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    model_reset();
    applyStimulus(4'b1111, '0, 1'b1);
    cycle("rst");
    Reset = 1'b0;
    applyStimulus('0, '0, 1'b1);
  endtask

  initial begin
    Reset = 1'b0;
    applyStimulus('0, '0, 1'b1);
    #2;
    doReset();

    // Single lookup from requester 0
    applyStimulus(4'b0001, 20'd1, 1'b1);
    @(negedge Clk);
    chk("t1_gnt_const", gnt, 32'b0001);
    chk("t1_pidx_const", pal_index, 32'd1);
    checkOutput("t1a");
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1);
    @(negedge Clk);
    chk("t1_valid_const", rsp_valid, 32'd1);
    chk("t1_id_const", rsp_id, 32'd0);
    chk("t1_rgb_const", rsp_rgb, 32'h000);
    checkOutput("t1b");
    @(posedge Clk); #1;

    // All four requesting: strict rotation
    doReset();
    applyStimulus(4'b1111, {5'd5, 5'd4, 5'd3, 5'd2}, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      chk("t2_order", gnt, 32'd1 << (c % 4));
      chk("t2_valid", rsp_valid, (c > 0) ? 32'd1 : 32'd0);
      checkOutput("t2");
      @(posedge Clk); #1;
    end
    applyStimulus('0, '0, 1'b1);
    cycle("t2tail");

    // Pointer wrap after a grant to the last requester
    doReset();
    applyStimulus(4'b1000, {5'd9, 15'd0}, 1'b1);
    @(negedge Clk);
    chk("t3_gnt3", gnt, 32'b1000);
    checkOutput("t3a");
    @(posedge Clk); #1;
    applyStimulus(4'b1001, {5'd9, 10'd0, 5'd6}, 1'b1);
    @(negedge Clk);
    chk("t3_gnt0_first", gnt, 32'b0001);
    checkOutput("t3b");
    @(posedge Clk); #1;
    cycle("t3c");

    // Stall holds the response and blocks grants
    doReset();
    applyStimulus(4'b0100, {5'd0, 5'd7, 10'd0}, 1'b1);
    cycle("t4a");
    applyStimulus(4'b0010, {10'd0, 5'd9, 5'd0}, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("t4_stall_gnt", gnt, 32'd0);
      chk("t4_stall_id", rsp_id, 32'd2);
      chk("t4_stall_rgb", rsp_rgb, 32'(pal_of(7)));
      checkOutput("t4s");
      @(posedge Clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    chk("t4_release_gnt", gnt, 32'b0010);
    checkOutput("t4r");
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1);
    @(negedge Clk);
    chk("t4_next_id", rsp_id, 32'd1);
    checkOutput("t4n");
    @(posedge Clk); #1;

    // Asynchronous reset in the middle of traffic
    applyStimulus(4'b1111, {5'd3, 5'd4, 5'd5, 5'd6}, 1'b1);
    cycle("t5a");
    #2;
    Reset = 1'b1;
    #1;
    chk("t5_async_valid", rsp_valid, 32'd0);
    chk("t5_rst_gnt", gnt, 32'd0);
    model_reset();
    cycle("t5r");
    Reset = 1'b0;
    @(negedge Clk);
    chk("t5_ptr_zero", gnt, 32'b0001);
    checkOutput("t5b");
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1);
    cycle("t5c");

    // Randomized traffic honouring the request/grant handshake
    doReset();
    for (int i = 0; i < N; i++) begin
      pending[i] = 0;
      pidx[i]    = '0;
    end
    gnt_seen = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt_seen[i]) pending[i] = 0;
        if (!pending[i] && ($urandom_range(0, 2) == 0)) begin
          pending[i] = 1;
          pidx[i]    = IW'($urandom);
        end
        req[i]          = pending[i];
        idx[i*IW +: IW] = pidx[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge Clk);
      chk("rnd_no_gnt_in_stall", ((rsp_valid && !rsp_ready) && (gnt != '0)) ? 32'd1 : 32'd0, 32'd0);
      checkOutput("rnd");
      @(posedge Clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, 1'b1);
      cycle("drain");
    end
    chk("sb_empty", sb_id.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
